piso_stream: RTL and testbench

- Parametrised, multi-lane parallel-in serial-out serialiser with a valid/ready input handshake and a one-word holding buffer.
- Each word is emitted as LANES bits per beat, so back-to-back words serialise with no idle gap.
- Emits start-of-word and end-of-word markers and supports per-word bit order.
- Sits between PE-array result registers and narrow serial links or off-chip pins; it is the generalised successor of piso_macro.

---
 rtl/piso_stream_pkg.sv | 18 +
 rtl/piso_stream_shift_core.sv | 69 ++++++
 rtl/piso_stream.sv | 93 +++++++++
 tb/tb_piso_stream.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_stream_pkg.sv
// Shared types and defaults for the piso_stream serialiser.
// Build option PISO_PARITY_EN (see piso_shift_core) adds a per-lane parity beat to every word.
package piso_stream_pkg;

    localparam int DATA_WIDTH         = 16;
    localparam int PISO_LANES_DEFAULT = 1;

    typedef enum logic {
        PISO_IDLE  = 1'b0,
        PISO_SHIFT = 1'b1
    } piso_state_e;

    // Wide enough to count BEATS+1 beats, so the parity build needs no other width.
    function automatic int piso_cnt_w(input int beats);
        return (beats < 1) ? 1 : $clog2(beats + 1);
    endfunction

endpackage

// File: rtl/piso_stream_shift_core.sv
// Shift register, beat counter and (PISO_PARITY_EN) per-lane parity accumulator.
// load wins over step; the word's bit order is latched on load.
module piso_shift_core
    import piso_stream_pkg::*;
#(
    parameter int PW    = DATA_WIDTH * 2,
    parameter int LANES = PISO_LANES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [PW-1:0]    word,
    input  logic             msb_first,
    output logic [LANES-1:0] beat,
    output logic             first,
    output logic             last
);
    localparam int BEATS = PW / LANES;
`ifdef PISO_PARITY_EN
    localparam int TOTAL = BEATS + 1;
`else
    localparam int TOTAL = BEATS;
`endif
    localparam int            CW       = piso_cnt_w(BEATS);
    localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL - 1);

    logic [PW-1:0]    sr;
    logic             msb;
    logic [CW-1:0]    cnt;
    logic [LANES-1:0] data_beat;

    // The live beat always sits at the end the word is drained from.
    assign data_beat = msb ? sr[PW-1 -: LANES] : sr[LANES-1:0];
    assign first     = (cnt == '0);
    assign last      = (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sr  <= '0;
            msb <= 1'b1;
            cnt <= '0;
        end else if (load) begin
            sr  <= word;
            msb <= msb_first;
            cnt <= '0;
        end else if (step) begin
            sr  <= msb ? (sr << LANES) : (sr >> LANES);
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

`ifdef PISO_PARITY_EN
    logic [LANES-1:0] acc;

    always_ff @(posedge clk) begin
        if (!rst || load) begin
            acc <= '0;
        end else if (step) begin
            acc <= acc ^ data_beat;
        end
    end

    assign beat = last ? acc : data_beat;
`else
    assign beat = data_beat;
`endif

endmodule

// File: rtl/piso_stream.sv
// Multi-lane PISO serialiser: valid/ready intake, one-word hold buffer, IDLE/SHIFT FSM.
// PISO_PARITY_EN appends a parity beat per word (implemented in piso_shift_core).
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int PW    = DATA_WIDTH * 2,
    parameter int LANES = PISO_LANES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PW-1:0]    p_in,
    input  logic             msb_first,
    input  logic             ce,
    output logic [LANES-1:0] s_out,
    output logic             out_valid,
    output logic             sof,
    output logic             eof
);
    if (PW % LANES != 0) begin : g_bad_lanes
        $error("piso_stream: PW must be a multiple of LANES");
    end

    typedef struct packed {
        logic          msb;
        logic [PW-1:0] data;
    } word_t;

    piso_state_e      state;
    word_t            hold;
    logic             hold_full;
    word_t            in_word;
    word_t            load_word;
    logic             accept;
    logic             consume;
    logic             free;
    logic             load;
    logic             first;
    logic             last;
    logic [LANES-1:0] beat;

    assign in_ready  = rst && !hold_full;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == PISO_SHIFT);
    assign consume   = out_valid && ce;
    assign free      = !out_valid || (consume && last);
    assign load      = free && (hold_full || accept);
    assign in_word   = {msb_first, p_in};
    assign load_word = hold_full ? hold : in_word;

    // in_ready is low whenever hold is full, so a hold->shifter move never coincides
    // with a new accept; the hold simply empties.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= PISO_IDLE;
            hold      <= '0;
            hold_full <= 1'b0;
        end else begin
            case (state)
                PISO_IDLE:  if (load) state <= PISO_SHIFT;
                PISO_SHIFT: if (consume && last && !load) state <= PISO_IDLE;
                default:    state <= PISO_IDLE;
            endcase
            if (load && hold_full) begin
                hold_full <= 1'b0;
            end else if (!load && accept) begin
                hold      <= in_word;
                hold_full <= 1'b1;
            end
        end
    end

    piso_shift_core #(
        .PW    (PW),
        .LANES (LANES)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .step      (consume),
        .word      (load_word.data),
        .msb_first (load_word.msb),
        .beat      (beat),
        .first     (first),
        .last      (last)
    );

    assign s_out = out_valid ? beat : '0;
    assign sof   = out_valid && first;
    assign eof   = out_valid && last;

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream: LANES=1 and LANES=4 instances against a
// beat-list reference model built from the bit-order rules.
module tb_piso_stream;

    typedef struct {
        logic [7:0] s;
        logic       sof;
        logic       eof;
        int         cyc;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid1 = 1'b0, in_valid4 = 1'b0;
    logic [31:0] p_in = '0;
    logic        msb_first = 1'b1;
    logic        ce;
    logic        ce_force = 1'b1, ce_rnd = 1'b1;
    bit          rand_ce = 1'b0;

    logic        in_ready1, out_valid1, sof1, eof1;
    logic [0:0]  s_out1;
    logic        in_ready4, out_valid4, sof4, eof4;
    logic [3:0]  s_out4;

    beat_t q1[$], q4[$], exp_q[$];
    int    cyc = 0, idle_bad = 0, ready_low = 0;
    int    checks = 0, errors = 0;

    assign ce = rand_ce ? ce_rnd : ce_force;

    always #5 clk = ~clk;

    piso_stream #(.PW(32), .LANES(1)) d1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .p_in(p_in),
        .msb_first(msb_first), .ce(ce), .s_out(s_out1), .out_valid(out_valid1),
        .sof(sof1), .eof(eof1));

    piso_stream #(.PW(32), .LANES(4)) d4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .p_in(p_in),
        .msb_first(msb_first), .ce(ce), .s_out(s_out4), .out_valid(out_valid4),
        .sof(sof4), .eof(eof4));

    // Record every consumed beat; flag any non-zero s_out while idle.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (out_valid1 && ce && rst) q1.push_back('{8'(s_out1), sof1, eof1, cyc});
        else if (!out_valid1 && s_out1 !== 1'b0) idle_bad++;
        if (out_valid4 && ce && rst) q4.push_back('{8'(s_out4), sof4, eof4, cyc});
        else if (!out_valid4 && s_out4 !== 4'd0) idle_bad++;
    end

    always begin
        @(negedge clk);
        #1;
        ce_rnd = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Expected beats of one word: slice k of the word in the requested order.
    function automatic void add_word(input logic [31:0] w, input logic m, input int lanes);
        int          beats;
        logic [7:0]  mask;
        logic [31:0] sh;
        beat_t       b;
`ifdef PISO_PARITY_EN
        logic [7:0]  par;
        par = '0;
`endif
        beats = 32 / lanes;
        mask  = 8'((1 << lanes) - 1);
        for (int k = 0; k < beats; k++) begin
            sh    = m ? (w >> (32 - (k + 1) * lanes)) : (w >> (k * lanes));
            b.s   = sh[7:0] & mask;
            b.sof = (k == 0);
            b.eof = (k == beats - 1);
            b.cyc = 0;
`ifdef PISO_PARITY_EN
            par   = par ^ b.s;
            b.eof = 1'b0;
`endif
            exp_q.push_back(b);
        end
`ifdef PISO_PARITY_EN
        b.s = par; b.sof = 1'b0; b.eof = 1'b1;
        exp_q.push_back(b);
`endif
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic push(input bit four, input logic [31:0] w, input logic m, output bit ok);
        ok = 1'b0;
        p_in = w;
        msb_first = m;
        if (four) in_valid4 = 1'b1; else in_valid1 = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if ((four ? in_ready4 : in_ready1) === 1'b1) ok = 1'b1;
            else ready_low++;
            step();
        end
    endtask

    task automatic test_reset();
        run(3);
        checks += 5;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid1); end
        if (s_out1 !== 1'b0) begin errors++; $display("FAIL rst_s_out got %b want 0", s_out1); end
        if (sof1 !== 1'b0 || eof1 !== 1'b0) begin errors++; $display("FAIL rst_markers got %b%b want 00", sof1, eof1); end
        if (in_ready1 !== 1'b0) begin errors++; $display("FAIL rst_in_ready1 got %b want 0", in_ready1); end
        if (in_ready4 !== 1'b0) begin errors++; $display("FAIL rst_in_ready4 got %b want 0", in_ready4); end
        rst = 1'b1;
        step();
        checks++;
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b want 1", in_ready1); end
    endtask

    task automatic test_word_order(input logic m);
        bit ok;
        q1.delete(); exp_q.delete();
        add_word(32'h0100_0001, m, 1);
        push(1'b0, 32'h0100_0001, m, ok);
        in_valid1 = 1'b0;
        checks += 2;
        if (!ok) begin errors++; $display("FAIL order%0b_accept got 0 want 1", m); end
        if (out_valid1 !== 1'b1 || sof1 !== 1'b1 || 8'(s_out1) !== exp_q[0].s)
            begin errors++; $display("FAIL order%0b_latency got v=%b sof=%b s=%b want v=1 sof=1 s=%0h", m, out_valid1, sof1, s_out1, exp_q[0].s); end
        run(45);
        checks += 2;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL order%0b_idle got %b want 0", m, out_valid1); end
        if (q1.size() !== exp_q.size()) begin errors++; $display("FAIL order%0b_len got %0d want %0d", m, q1.size(), exp_q.size()); end
        for (int i = 0; i < q1.size() && i < exp_q.size(); i++) begin
            checks++;
            if (q1[i].s !== exp_q[i].s || q1[i].sof !== exp_q[i].sof || q1[i].eof !== exp_q[i].eof)
                begin errors++; $display("FAIL order%0b_beat%0d got s=%0h sof=%b eof=%b want s=%0h sof=%b eof=%b", m, i, q1[i].s, q1[i].sof, q1[i].eof, exp_q[i].s, exp_q[i].sof, exp_q[i].eof); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int nacc, gaps, nsof, neof;
        logic [31:0] words [3];
        words = '{32'h0100_0001, 32'h0100_0000, 32'h0100_0001};
        q1.delete(); exp_q.delete();
        ready_low = 0; nacc = 0;
        foreach (words[i]) begin
            add_word(words[i], 1'b1, 1);
            push(1'b0, words[i], 1'b1, ok);
            if (ok) nacc++;
        end
        in_valid1 = 1'b0;
        run(120);
        gaps = 0; nsof = 0; neof = 0;
        foreach (q1[i]) begin
            if (i > 0 && q1[i].cyc != q1[i-1].cyc + 1) gaps++;
            nsof += int'(q1[i].sof);
            neof += int'(q1[i].eof);
        end
        checks += 6;
        if (nacc !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", nacc); end
        if (ready_low == 0) begin errors++; $display("FAIL b2b_ready_drop got %0d low cycles want >0", ready_low); end
        if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps got %0d want 0", gaps); end
        if (nsof !== 3 || neof !== 3) begin errors++; $display("FAIL b2b_markers got sof=%0d eof=%0d want 3 3", nsof, neof); end
        if (q1.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_len got %0d want %0d", q1.size(), exp_q.size()); end
        if (idle_bad !== 0) begin errors++; $display("FAIL b2b_idle_s_out got %0d want 0", idle_bad); end
        for (int i = 0; i < q1.size() && i < exp_q.size(); i++) begin
            checks++;
            if (q1[i].s !== exp_q[i].s || q1[i].sof !== exp_q[i].sof || q1[i].eof !== exp_q[i].eof)
                begin errors++; $display("FAIL b2b_beat%0d got s=%0h sof=%b eof=%b want s=%0h sof=%b eof=%b", i, q1[i].s, q1[i].sof, q1[i].eof, exp_q[i].s, exp_q[i].sof, exp_q[i].eof); end
        end
    endtask

    task automatic test_lanes4();
        bit ok;
        logic [31:0] w2;
        w2 = $urandom;
        q4.delete(); exp_q.delete();
        add_word(32'hDEAD_BEEF, 1'b1, 4);
        add_word(w2, 1'b0, 4);
        push(1'b1, 32'hDEAD_BEEF, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL l4_accept got 0 want 1"); end
        push(1'b1, w2, 1'b0, ok);
        in_valid4 = 1'b0;
        run(30);
        checks++;
        if (q4.size() !== exp_q.size()) begin errors++; $display("FAIL l4_len got %0d want %0d", q4.size(), exp_q.size()); end
        for (int i = 0; i < q4.size() && i < exp_q.size(); i++) begin
            checks++;
            if (q4[i].s !== exp_q[i].s || q4[i].sof !== exp_q[i].sof || q4[i].eof !== exp_q[i].eof)
                begin errors++; $display("FAIL l4_beat%0d got s=%0h sof=%b eof=%b want s=%0h sof=%b eof=%b", i, q4[i].s, q4[i].sof, q4[i].eof, exp_q[i].s, exp_q[i].sof, exp_q[i].eof); end
        end
    endtask

    task automatic test_stall();
        bit ok;
        q1.delete(); exp_q.delete();
        add_word(32'h0100_0001, 1'b1, 1);
        push(1'b0, 32'h0100_0001, 1'b1, ok);
        in_valid1 = 1'b0;
        for (int i = 0; i < 60 && q1.size() < 10; i++) step();
        ce_force = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid1 !== 1'b1 || 8'(s_out1) !== exp_q[10].s || sof1 !== 1'b0 || eof1 !== 1'b0)
                begin errors++; $display("FAIL stall_cyc%0d got v=%b s=%b sof=%b eof=%b want v=1 s=%0h sof=0 eof=0", i, out_valid1, s_out1, sof1, eof1, exp_q[10].s); end
            step();
        end
        ce_force = 1'b1;
        run(40);
        checks++;
        if (q1.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len got %0d want %0d", q1.size(), exp_q.size()); end
        for (int i = 0; i < q1.size() && i < exp_q.size(); i++) begin
            checks++;
            if (q1[i].s !== exp_q[i].s || q1[i].sof !== exp_q[i].sof || q1[i].eof !== exp_q[i].eof)
                begin errors++; $display("FAIL stall_beat%0d got s=%0h sof=%b eof=%b want s=%0h sof=%b eof=%b", i, q1[i].s, q1[i].sof, q1[i].eof, exp_q[i].s, exp_q[i].sof, exp_q[i].eof); end
        end
    endtask

    task automatic test_reset_midword();
        bit ok;
        q1.delete(); exp_q.delete();
        add_word(32'h8421_F00D, 1'b1, 1);
        push(1'b0, 32'h8421_F00D, 1'b1, ok);
        push(1'b0, 32'hFFFF_FFFF, 1'b0, ok);
        in_valid1 = 1'b0;
        checks++;
        if (in_ready1 !== 1'b0) begin errors++; $display("FAIL rstmid_hold_full got ready=%b want 0", in_ready1); end
        for (int i = 0; i < 60 && q1.size() < 12; i++) step();
        rst = 1'b0;
        step();
        checks += 3;
        if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid1); end
        if (s_out1 !== 1'b0) begin errors++; $display("FAIL rstmid_s_out got %b want 0", s_out1); end
        if (in_ready1 !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %b want 0", in_ready1); end
        rst = 1'b1;
        step();
        checks++;
        if (in_ready1 !== 1'b1) begin errors++; $display("FAIL rstmid_release_ready got %b want 1", in_ready1); end
        run(60);
        checks++;
        if (q1.size() !== 12) begin errors++; $display("FAIL rstmid_stale got %0d beats want 12", q1.size()); end
        for (int i = 0; i < q1.size() && i < 12; i++) begin
            checks++;
            if (q1[i].s !== exp_q[i].s || q1[i].sof !== exp_q[i].sof)
                begin errors++; $display("FAIL rstmid_beat%0d got s=%0h sof=%b want s=%0h sof=%b", i, q1[i].s, q1[i].sof, exp_q[i].s, exp_q[i].sof); end
        end
    endtask

    task automatic test_random();
        bit ok;
        logic [31:0] w;
        logic m;
        q1.delete(); exp_q.delete();
        rand_ce = 1'b1;
        for (int n = 0; n < 6; n++) begin
            w = $urandom;
            m = 1'($urandom_range(0, 1));
            add_word(w, m, 1);
            push(1'b0, w, m, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rand_accept%0d got 0 want 1", n); end
            if (n[0]) begin
                in_valid1 = 1'b0;
                run($urandom_range(0, 40));
            end
        end
        in_valid1 = 1'b0;
        run(400);
        rand_ce = 1'b0;
        checks += 2;
        if (q1.size() !== exp_q.size()) begin errors++; $display("FAIL rand_len got %0d want %0d", q1.size(), exp_q.size()); end
        if (idle_bad !== 0) begin errors++; $display("FAIL rand_idle_s_out got %0d want 0", idle_bad); end
        for (int i = 0; i < q1.size() && i < exp_q.size(); i++) begin
            checks++;
            if (q1[i].s !== exp_q[i].s || q1[i].sof !== exp_q[i].sof || q1[i].eof !== exp_q[i].eof)
                begin errors++; $display("FAIL rand_beat%0d got s=%0h sof=%b eof=%b want s=%0h sof=%b eof=%b", i, q1[i].s, q1[i].sof, q1[i].eof, exp_q[i].s, exp_q[i].sof, exp_q[i].eof); end
        end
    endtask

    initial begin
        test_reset();
        test_word_order(1'b1);
        test_word_order(1'b0);
        test_back_to_back();
        test_lanes4();
        test_stall();
        test_reset_midword();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
